// File: rtl/fetch_pc_unit.sv
// Fetch/PC stage: holds the PC, fetches over a req/ack handshake, and selects the next PC on retirement.
// Optional FETCH_COUNT_EN adds retired_count / taken_count outputs.
module fetch_pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] retired_count,
  output logic [31:0] taken_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] seq_pc_s, jmp_target_s, br_target_s, next_pc_s;
  logic        retire_s, take_s;

  assign retire_s     = (state_q == S_ISSUE) && instr_ready;
  assign take_s       = jump || (branch && (zero ^ bne));
  assign seq_pc_s     = pc_q + 32'd4;
  assign jmp_target_s = {seq_pc_s[31:28], instr_q[25:0], 2'b00};
  assign br_target_s  = seq_pc_s + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (imem_ack) state_d = S_ISSUE; else state_d = S_FETCH;
      S_ISSUE: if (instr_ready) state_d = S_FETCH; else state_d = S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_ISSUE: instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  // Next-PC select; jump outranks branch because control raises Branch during J
  always_comb begin
    next_pc_s = seq_pc_s;
    if (jump) begin
      next_pc_s = jmp_target_s;
    end else if (branch && (zero ^ bne)) begin
      next_pc_s = br_target_s;
    end else begin
      next_pc_s = seq_pc_s;
    end
  end

  // Datapath next-state: capture on ack in FETCH, advance PC on retirement
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if ((state_q == S_FETCH) && imem_ack) begin
      instr_d = imem_rdata;
    end else begin
      instr_d = instr_q;
    end
    if (retire_s) begin
      pc_d = next_pc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC and instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'h0000_0000;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = seq_pc_s;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];

`ifdef FETCH_COUNT_EN
  logic [31:0] retired_q, retired_d, taken_q, taken_d;

  // Retirement counter next-state
  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (retire_s) begin
      retired_d = retired_q + 32'd1;
      if (take_s) taken_d = taken_q + 32'd1; else taken_d = taken_q;
    end else begin
      retired_d = retired_q;
      taken_d   = taken_q;
    end
  end

  // Retirement counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'h0000_0000;
      taken_q   <= 32'h0000_0000;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign retired_count = retired_q;
  assign taken_count   = taken_q;
`endif

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch and program-counter stage of the single-cycle MIPS datapath. It sits directly upstream of the control unit. It holds the PC and fetches a word from instruction memory over a request/acknowledge handshake. It presents the instruction and its opcode to decode, and it computes the next PC from the control unit's Branch/Bne/Jump outputs and the ALU zero flag once the instruction retires.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ack  input  1  memory has returned imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  registered instruction presented to decode.
- opcode  output  6  instr[31:26], to the control unit.
- instr_valid  output  1  instr holds a fetched, not-yet-retired instruction.
- instr_ready  input  1  datapath retires the current instruction this cycle.
- branch  input  1  control Branch output.
- bne  input  1  control Bne output.
- jump  input  1  control Jump output.
- zero  input  1  ALU zero flag for the current instruction.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32.

## Operation
- The FSM has three states: IDLE, FETCH and ISSUE.
- IDLE is the reset state. It moves unconditionally to FETCH on the next edge.
- In FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - When imem_ack=1 at the edge: instr<=imem_rdata and the FSM moves to ISSUE.
- In ISSUE:
  - instr_valid=1 and imem_req=0.
  - When instr_ready=1 at the edge: pc<=next_pc and the FSM moves to FETCH.
  - Without instr_ready, instr, pc and instr_valid hold indefinitely.
- next_pc is evaluated from the inputs sampled in the retiring cycle, in this priority order:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump overrides branch, because control asserts Branch during J.
  - branch=1 and (zero XOR bne)=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), 32-bit wrap.
  - Otherwise: pc_plus4.
- All adders are 32-bit and discard carry-out. PC 32'hFFFF_FFFC + 4 wraps to 0.
- imem_ack is ignored outside FETCH.
- instr_ready is ignored outside ISSUE.
- branch, bne, jump and zero are only sampled when instr_ready=1 in ISSUE. X on these inputs at any other time has no effect.
- Reset values: state=IDLE, pc=PC_RESET, instr=0, opcode=0, instr_valid=0, imem_req=0, pc_plus4=PC_RESET+4.
- Reset mid-operation: rst=1 at any edge, including during a pending fetch or an ack cycle, forces the reset values.
  - A simultaneous imem_ack is dropped.
  - The fetch restarts at PC_RESET, with imem_req first re-asserted one cycle after the cycle in which IDLE is entered.

## Timing
- imem_req rises one cycle after leaving IDLE.
- With zero-wait memory (imem_ack in the first request cycle), instr_valid rises on the next cycle.
- Minimum throughput: one instruction per 2 cycles (FETCH, ISSUE). Each memory wait cycle adds 1.
- imem_req falls in the cycle after the ack edge. No back-to-back requests occur without an intervening ISSUE cycle.
- pc updates on the same edge at which instr_valid falls. imem_addr reflects the new pc in that next FETCH cycle.
- All outputs are registered or decoded directly from registers. There is no combinational path from imem_ack or instr_ready to any output.

## Configuration
- FETCH_COUNT_EN is defined: two extra 32-bit outputs are added, retired_count and taken_count.
  - Both reset to 0.
  - retired_count increments on every ISSUE edge with instr_ready=1.
  - taken_count increments when that retirement selected a jump or taken-branch target.
  - Both wrap modulo 2^32.
- FETCH_COUNT_EN is undefined: those ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset, then sequential fetch with zero-wait ack: imem_addr = 0, 4, 8 on successive requests; instr_valid is high every 2nd cycle.
- Memory latency of 3 cycles: imem_addr is held stable for 4 request cycles; instr equals imem_rdata from the ack cycle; instr_valid rises the next cycle.
- Taken and not-taken branches:
  - beq at pc=0x10 with imm=0xFFFE, branch=1, bne=0, zero=1 → next pc=0x0C.
  - Same instruction with zero=0 → pc=0x14.
  - bne=1 with zero=0 → pc=0x0C.
- Jump: pc=0x3000_0000 with instr[25:0]=0x0000100, jump=1 and branch=1 → next pc=0x3000_0400.
- Stall, then reset mid-fetch:
  - Hold instr_ready=0 for 5 cycles: instr and pc are unchanged.
  - Then assert rst with imem_ack=1 during FETCH: the ack is ignored, pc=PC_RESET, and imem_req restarts at address 0.
- With FETCH_COUNT_EN defined, after 3 retirements including 1 jump: retired_count=3, taken_count=1.
